// File: rtl/down_count_sequencer_if.sv
// down_count_sequencer_if: start/busy/done handshake and counter-control bundle
interface down_count_sequencer_if #(
   parameter int WIDTH  = 4,
   parameter int REPS_W = 4
);
   logic              start;
   logic              pause;
   logic              abort;
   logic              cnt_load;
   logic              cnt_en;
   logic              busy;
   logic              tc;
   logic              done;
   logic [WIDTH-1:0]  preset;
   logic [WIDTH-1:0]  cnt_q;
   logic [WIDTH-1:0]  cnt_value;
   logic [REPS_W-1:0] reps;
   logic [REPS_W-1:0] pass_cnt;
   modport master (
      output start, preset, reps, pause, abort, cnt_q,
      input  cnt_load, cnt_value, cnt_en, busy, tc, done, pass_cnt
   );
   modport slave (
      input  start, preset, reps, pause, abort, cnt_q,
      output cnt_load, cnt_value, cnt_en, busy, tc, done, pass_cnt
   );
endinterface

// File: rtl/down_count_sequencer.sv
// down_count_sequencer: load/enable controller for an external down counter, repeating passes
module down_count_sequencer #(
   parameter int WIDTH  = 4,
   parameter int REPS_W = 4
) (
   input logic                   clk,
   input logic                   rst,
   down_count_sequencer_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LOAD, COUNT, HOLD, DONE} state_t;
   state_t            state, state_nxt;
   logic [WIDTH-1:0]  preset_q;
   logic [REPS_W-1:0] reps_q, pass_q, pass_inc;
   logic              accept, term, last;
   assign accept   = state == IDLE && bus.start && !bus.abort;
   assign term     = state == COUNT && bus.cnt_q == '0 && !bus.abort;
   assign pass_inc = pass_q + REPS_W'(1);
   assign last     = |reps_q && pass_inc == reps_q;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = accept ? LOAD : IDLE;
         LOAD:    state_nxt = COUNT;
         COUNT:   state_nxt = term ? (last ? DONE : LOAD) : (bus.pause ? HOLD : COUNT);
         HOLD:    state_nxt = bus.pause ? HOLD : COUNT;
         default: state_nxt = IDLE;
      endcase
      if (bus.abort) state_nxt = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         preset_q <= '0;
         reps_q   <= '0;
         pass_q   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            preset_q <= bus.preset;
            reps_q   <= bus.reps;
            pass_q   <= '0;
         end else if (term) begin
            pass_q <= pass_inc;
         end
      end
   end
   // abort masks every pulse in the cycle it is seen
   assign bus.cnt_load  = state == LOAD && !bus.abort;
   assign bus.cnt_en    = state == COUNT && bus.cnt_q != '0 && !bus.pause && !bus.abort;
   assign bus.tc        = term;
   assign bus.done      = state == DONE && !bus.abort;
   assign bus.busy      = state inside {LOAD, COUNT, HOLD};
   assign bus.cnt_value = preset_q;
   assign bus.pass_cnt  = pass_q;
endmodule

// File: tb/tb_down_count_sequencer.sv
// tb_down_count_sequencer: per-cycle expected traces built from pass arithmetic, checked against the DUT
module tb_down_count_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   down_count_sequencer_if #(.WIDTH(4), .REPS_W(4)) bus ();
   down_count_sequencer #(.WIDTH(4), .REPS_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   logic [3:0] cnt = 4'd0;
   always_ff @(posedge clk) cnt <= bus.cnt_load ? bus.cnt_value : bus.cnt_en ? cnt - 4'd1 : cnt;
   assign bus.cnt_q = cnt;
   typedef struct {
      bit start, pause, abort, load, en, tc, done, busy, chk_cnt, chk_val;
      int pass, cnt;
   } cyc_t;
   cyc_t q[$];
   int   ps[$];
   int   tests = 0, fails = 0, last_pass = 0, cur_p = 0, cur_r = 0, idx = 0;
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   function automatic bit coin();
      return 1'($urandom_range(0, 1));
   endfunction
   function automatic cyc_t mk(bit pause, bit load, bit en, bit tc, bit done, bit busy, int pass, int cv, bit chk_cnt);
      cyc_t c;
      c = '{default: 0};
      c.start = coin();
      c.pause = pause;
      c.load = load;
      c.en = en;
      c.tc = tc;
      c.done = done;
      c.busy = busy;
      c.pass = pass;
      c.cnt = cv;
      c.chk_cnt = chk_cnt;
      c.chk_val = 1'b1;
      return c;
   endfunction
   // one pass = LOAD, preset counting cycles (each pause burst of len adds len+1 stalls), terminal
   task automatic build(int p, int r, int npass, int pv, int plen, int pct);
      cyc_t c;
      int n;
      n = (r == 0) ? npass : r;
      cur_p = p;
      cur_r = r;
      q.delete();
      ps.delete();
      c = mk(coin(), 0, 0, 0, 0, 0, last_pass, 0, 0);
      c.start = 1'b1;
      c.chk_val = 1'b0;
      q.push_back(c);
      for (int k = 0; k < n; k++) begin
         ps.push_back(q.size());
         q.push_back(mk(coin(), 1, 0, 0, 0, 1, k % 16, 0, 0));
         for (int v = p; v >= 1; v--) begin
            int len;
            len = (v == pv) ? plen : ($urandom_range(1, 100) <= pct) ? int'($urandom_range(1, 3)) : 0;
            if (len > 0) begin
               for (int j = 0; j < len; j++) q.push_back(mk(1, 0, 0, 0, 0, 1, k % 16, v, 1));
               q.push_back(mk(0, 0, 0, 0, 0, 1, k % 16, v, 1));
            end
            q.push_back(mk(0, 0, 1, 0, 0, 1, k % 16, v, 1));
         end
         q.push_back(mk(coin(), 0, 0, 1, 0, 1, k % 16, 0, 1));
      end
      if (r != 0) q.push_back(mk(coin(), 0, 0, 0, 1, 0, r, 0, 0));
   endtask
   task automatic apply_abort(int at);
      while (q.size() > at + 1) void'(q.pop_back());
      q[at].abort = 1'b1;
      q[at].load = 1'b0;
      q[at].en = 1'b0;
      q[at].tc = 1'b0;
      q[at].done = 1'b0;
   endtask
   task automatic close();
      cyc_t c;
      c = mk(0, 0, 0, 0, 0, 0, q[q.size()-1].pass, 0, 0);
      c.start = 1'b0;
      c.chk_val = q[q.size()-1].chk_val;
      q.push_back(c);
   endtask
   task automatic run(int n);
      for (int i = 0; i < n && i < q.size(); i++) begin
         @(posedge clk);
         #1;
         bus.start = q[i].start;
         bus.pause = q[i].pause;
         bus.abort = q[i].abort;
         bus.preset = (i == 0) ? 4'(cur_p) : 4'($urandom);
         bus.reps = (i == 0) ? 4'(cur_r) : 4'($urandom);
         #1;
         chk($sformatf("cnt_load@%0d", i), 32'(bus.cnt_load), 32'(q[i].load));
         chk($sformatf("cnt_en@%0d", i), 32'(bus.cnt_en), 32'(q[i].en));
         chk($sformatf("tc@%0d", i), 32'(bus.tc), 32'(q[i].tc));
         chk($sformatf("done@%0d", i), 32'(bus.done), 32'(q[i].done));
         chk($sformatf("busy@%0d", i), 32'(bus.busy), 32'(q[i].busy));
         chk($sformatf("pass_cnt@%0d", i), 32'(bus.pass_cnt), q[i].pass);
         if (q[i].chk_cnt) chk($sformatf("cnt_q@%0d", i), 32'(cnt), q[i].cnt);
         if (q[i].chk_val) chk($sformatf("cnt_value@%0d", i), 32'(bus.cnt_value), cur_p);
      end
      if (n >= q.size()) last_pass = q[q.size()-1].pass;
   endtask
   task automatic check_idle_zero(string tag);
      chk({tag, "_load"}, 32'(bus.cnt_load), 0);
      chk({tag, "_en"}, 32'(bus.cnt_en), 0);
      chk({tag, "_tc"}, 32'(bus.tc), 0);
      chk({tag, "_done"}, 32'(bus.done), 0);
      chk({tag, "_busy"}, 32'(bus.busy), 0);
      chk({tag, "_pass"}, 32'(bus.pass_cnt), 0);
      chk({tag, "_value"}, 32'(bus.cnt_value), 0);
   endtask
   initial begin
      bus.start = 1'b0;
      bus.pause = 1'b0;
      bus.abort = 1'b0;
      bus.preset = 4'd0;
      bus.reps = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      check_idle_zero("reset");
      rst = 1'b0;
      build(5, 2, 0, -1, 0, 0);
      close();
      run(q.size());
      build(0, 1, 0, -1, 0, 0);
      close();
      run(q.size());
      build(9, 1, 0, 6, 3, 0);
      close();
      run(q.size());
      build(7, 0, 4, -1, 0, 0);
      apply_abort(ps[3] + 5);
      close();
      run(q.size());
      build(1, 0, 18, -1, 0, 0);
      apply_abort(ps[17]);
      close();
      run(q.size());
      build(3, 1, 0, -1, 0, 0);
      apply_abort(0);
      close();
      run(q.size());
      build(6, 3, 0, -1, 0, 0);
      run(5);
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.start = 1'b1;
      bus.pause = 1'b0;
      bus.abort = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.start = 1'b0;
      #1;
      check_idle_zero("midrst");
      last_pass = 0;
      for (int s = 0; s < 12; s++) begin
         build(int'($urandom_range(0, 15)), int'($urandom_range(0, 4)), int'($urandom_range(1, 3)), -1, 0, 25);
         if (cur_r == 0 || $urandom_range(0, 2) == 0) begin
            idx = int'($urandom_range(0, q.size() - 1));
            apply_abort(idx);
         end
         close();
         run(q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
